// File: rtl/mod3719_frame_accumulator_if.sv
// -----------------------------------------------------------------------------
// mod3719_frame_accumulator_if
// Streaming handshake bundle for the frame accumulator.
//   in_valid / in_data / in_ready    : upstream residue stream (Barrett output)
//   out_valid / out_sum / out_ready  : downstream frame-sum stream
// master : the environment (drives residues, consumes sums)
// slave  : the accumulator
// -----------------------------------------------------------------------------
interface mod3719_frame_accumulator_if;
    logic        in_valid;
    logic [11:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] out_sum;
    logic        out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum
    );
endinterface

// File: rtl/mod3719_frame_accumulator.sv
// -----------------------------------------------------------------------------
// mod3719_frame_accumulator
// Sums FRAME_LEN residues modulo Q and presents the frame sum on a
// valid/ready output. Two-state FSM: ACCUM (taking beats) and HOLD (sum
// presented, input stalled). One bubble cycle per frame on the input side.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : handshake bundle (slave side), see mod3719_frame_accumulator_if
//   err_clr   : synchronous clear of err_range
//   err_range : sticky flag, an accepted residue was >= Q
// -----------------------------------------------------------------------------
module mod3719_frame_accumulator #(
    parameter int Q         = 3719,
    parameter int FRAME_LEN = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    mod3719_frame_accumulator_if.slave        bus,
    input  logic                              err_clr,
    output logic                              err_range
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [12:0] Q13   = 13'(Q);
    localparam logic [15:0] LEN16 = 16'(FRAME_LEN);

    state_t      state_r;
    state_t      state_next_s;
    logic [11:0] acc_r;
    logic [15:0] cnt_r;
    logic [11:0] out_sum_r;
    logic        err_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic        in_ready_next_s;
    logic        out_valid_next_s;

    logic        accept_s;
    logic        drain_s;
    logic        range_err_s;
    logic        last_beat_s;
    logic [11:0] x_norm_s;
    logic [12:0] sum_s;
    logic [12:0] sum_red_s;
    logic [11:0] acc_next_s;

    // Handshake qualifiers; in_ready_r is also low straight out of reset.
    assign accept_s    = bus.in_valid && in_ready_r && (state_r == ST_ACCUM);
    assign drain_s     = out_valid_r && bus.out_ready && (state_r == ST_HOLD);
    assign range_err_s = ({1'b0, bus.in_data} >= Q13);
    assign last_beat_s = accept_s && ((cnt_r + 16'd1) == LEN16);

    // Residue normalisation and modular add (one conditional subtract each).
    always_comb begin
        x_norm_s  = bus.in_data;
        sum_s     = 13'd0;
        sum_red_s = 13'd0;
        if (range_err_s) begin
            x_norm_s = bus.in_data - Q13[11:0];
        end else begin
            x_norm_s = bus.in_data;
        end
        sum_s = {1'b0, acc_r} + {1'b0, x_norm_s};
        if (sum_s >= Q13) begin
            sum_red_s = sum_s - Q13;
        end else begin
            sum_red_s = sum_s;
        end
    end

    assign acc_next_s = sum_red_s[11:0];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_ACCUM;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_ACCUM: begin
                if (last_beat_s) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (drain_s) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: state_next_s = ST_ACCUM;
        endcase
    end

    // FSM output decode, computed from the next state so the flags register.
    always_comb begin
        in_ready_next_s  = 1'b0;
        out_valid_next_s = 1'b0;
        case (state_next_s)
            ST_ACCUM: begin
                in_ready_next_s  = 1'b1;
                out_valid_next_s = 1'b0;
            end
            ST_HOLD: begin
                in_ready_next_s  = 1'b0;
                out_valid_next_s = 1'b1;
            end
            default: begin
                in_ready_next_s  = 1'b0;
                out_valid_next_s = 1'b0;
            end
        endcase
    end

    // Registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_next_s;
            out_valid_r <= out_valid_next_s;
        end
    end

    // Accumulator, beat counter and frame-sum register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= 12'd0;
            cnt_r     <= 16'd0;
            out_sum_r <= 12'd0;
        end else if (drain_s) begin
            acc_r     <= 12'd0;
            cnt_r     <= 16'd0;
            out_sum_r <= out_sum_r;
        end else if (accept_s) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + 16'd1;
            if (last_beat_s) begin
                out_sum_r <= acc_next_s;
            end else begin
                out_sum_r <= out_sum_r;
            end
        end else begin
            acc_r     <= acc_r;
            cnt_r     <= cnt_r;
            out_sum_r <= out_sum_r;
        end
    end

    // Sticky range error; a coincident bad beat beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (accept_s && range_err_s) begin
            err_r <= 1'b1;
        end else if (err_clr) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = out_sum_r;
    assign err_range     = err_r;

endmodule

// File: tb/tb_mod3719_frame_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mod3719_frame_accumulator
// Directed-vector bench for mod3719_frame_accumulator. Two instances:
// FRAME_LEN=4 for the frame scenarios and FRAME_LEN=1 for single-beat frames.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_mod3719_frame_accumulator;

    logic clk;
    logic rst_n;
    logic err_clr4;
    logic err_range4;
    logic err_clr1;
    logic err_range1;

    int vectors;
    int miscompares;

    mod3719_frame_accumulator_if bus4 ();
    mod3719_frame_accumulator_if bus1 ();

    mod3719_frame_accumulator #(.Q(3719), .FRAME_LEN(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus4),
        .err_clr   (err_clr4),
        .err_range (err_range4)
    );

    mod3719_frame_accumulator #(.Q(3719), .FRAME_LEN(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus1),
        .err_clr   (err_clr1),
        .err_range (err_range1)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        if (obs !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [11:0] x);
        bus4.in_valid = 1'b1;
        bus4.in_data  = x;
        step();
    endtask

    // Four back-to-back beats, then check the presented sum.
    task automatic frame4(input string tag, input logic [11:0] a, input logic [11:0] b,
                          input logic [11:0] c, input logic [11:0] d, input logic [11:0] exp);
        beat(a);
        beat(b);
        beat(c);
        check({tag, "_ov_before_last"}, 32'(bus4.out_valid), 32'd0);
        beat(d);
        bus4.in_valid = 1'b0;
        check({tag, "_ov"},  32'(bus4.out_valid), 32'd1);
        check({tag, "_ir"},  32'(bus4.in_ready),  32'd0);
        check({tag, "_sum"}, 32'(bus4.out_sum),   32'(exp));
    endtask

    task automatic handshake4(input string tag);
        bus4.out_ready = 1'b1;
        step();
        bus4.out_ready = 1'b0;
        check({tag, "_ov_drop"}, 32'(bus4.out_valid), 32'd0);
        check({tag, "_ir_rise"}, 32'(bus4.in_ready),  32'd1);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        err_clr4       = 1'b0;
        err_clr1       = 1'b0;
        bus4.in_valid  = 1'b0;
        bus4.in_data   = 12'd0;
        bus4.out_ready = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = 12'd0;
        bus1.out_ready = 1'b0;

        // Reset state.
        #3;
        check("rst_ir",  32'(bus4.in_ready),  32'd0);
        check("rst_ov",  32'(bus4.out_valid), 32'd0);
        check("rst_sum", 32'(bus4.out_sum),   32'd0);
        check("rst_err", 32'(err_range4),     32'd0);
        step();
        check("rst_ir_edge", 32'(bus4.in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_ir_before_edge", 32'(bus4.in_ready), 32'd0);
        step();
        check("rel_ir_after_edge", 32'(bus4.in_ready), 32'd1);

        // 4 x 1000 = 4000 -> 281.
        frame4("f1000", 12'd1000, 12'd1000, 12'd1000, 12'd1000, 12'd281);
        check("f1000_err", 32'(err_range4), 32'd0);
        handshake4("f1000");

        // Exact wrap at Q.
        frame4("fwrap", 12'd3718, 12'd1, 12'd0, 12'd0, 12'd0);
        handshake4("fwrap");

        // Out-of-range beat: 4000 -> 281, flag sets after the first beat.
        beat(12'd4000);
        check("oor_err_beat1", 32'(err_range4), 32'd1);
        beat(12'd0);
        beat(12'd0);
        beat(12'd0);
        bus4.in_valid = 1'b0;
        check("oor_sum", 32'(bus4.out_sum), 32'd281);
        check("oor_err_hold", 32'(err_range4), 32'd1);
        handshake4("oor");
        err_clr4 = 1'b1;
        step();
        err_clr4 = 1'b0;
        check("oor_err_clr", 32'(err_range4), 32'd0);
        // Clear coinciding with a bad beat: set wins; 4095 -> 376.
        err_clr4 = 1'b1;
        beat(12'd4095);
        err_clr4 = 1'b0;
        check("oor_err_setwins", 32'(err_range4), 32'd1);
        beat(12'd0);
        beat(12'd0);
        beat(12'd0);
        bus4.in_valid = 1'b0;
        check("oor4095_sum", 32'(bus4.out_sum), 32'd376);
        handshake4("oor4095");
        err_clr4 = 1'b1;
        step();
        err_clr4 = 1'b0;
        check("oor_err_clr2", 32'(err_range4), 32'd0);

        // Backpressure in HOLD with in_valid held high.
        frame4("fbp", 12'd10, 12'd20, 12'd30, 12'd40, 12'd100);
        bus4.in_valid = 1'b1;
        bus4.in_data  = 12'd7;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_sum", 32'(bus4.out_sum),   32'd100);
            check("bp_ir",  32'(bus4.in_ready),  32'd0);
            check("bp_ov",  32'(bus4.out_valid), 32'd1);
        end
        bus4.out_ready = 1'b1;
        step();
        bus4.out_ready = 1'b0;
        bus4.in_valid  = 1'b0;
        check("bp_ir_rise", 32'(bus4.in_ready), 32'd1);
        frame4("f2222", 12'd2, 12'd2, 12'd2, 12'd2, 12'd8);
        handshake4("f2222");

        // Reset mid-frame discards the partial sum.
        beat(12'd500);
        beat(12'd500);
        bus4.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ir", 32'(bus4.in_ready),  32'd0);
        check("mid_rst_ov", 32'(bus4.out_valid), 32'd0);
        step();
        rst_n = 1'b1;
        check("mid_rst_ov_edge", 32'(bus4.out_valid), 32'd0);
        step();
        check("mid_rst_ir_back", 32'(bus4.in_ready), 32'd1);
        frame4("f1111", 12'd1, 12'd1, 12'd1, 12'd1, 12'd4);
        handshake4("f1111");

        // FRAME_LEN=1: 3719 -> 0, bubble, 5 -> 5.
        check("l1_ir_idle", 32'(bus1.in_ready), 32'd1);
        bus1.out_ready = 1'b1;
        bus1.in_valid  = 1'b1;
        bus1.in_data   = 12'd3719;
        step();
        bus1.in_data = 12'd5;
        check("l1_ov_a",  32'(bus1.out_valid), 32'd1);
        check("l1_sum_a", 32'(bus1.out_sum),   32'd0);
        check("l1_ir_a",  32'(bus1.in_ready),  32'd0);
        check("l1_err",   32'(err_range1),     32'd1);
        step();
        check("l1_bubble_ov", 32'(bus1.out_valid), 32'd0);
        check("l1_bubble_ir", 32'(bus1.in_ready),  32'd1);
        step();
        bus1.in_valid = 1'b0;
        check("l1_ov_b",  32'(bus1.out_valid), 32'd1);
        check("l1_sum_b", 32'(bus1.out_sum),   32'd5);
        step();
        bus1.out_ready = 1'b0;
        check("l1_drain", 32'(bus1.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mod3719_frame_accumulator.md
MOD3719_FRAME_ACCUMULATOR -- requirements
Module: mod3719_frame_accumulator

Interface
REQ-001 The block SHALL have parameter Q, default 3719, the modulus.
REQ-002 The block SHALL have parameter FRAME_LEN, default 16, the number of residues per frame; legal range is 1..65535.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream residue (Barrett reducer output) is valid.
REQ-006 The block SHALL have port in_data, input, 12 bits: the residue, nominally < Q.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the frame sum is available.
REQ-009 The block SHALL have port out_sum, output, 12 bits: the frame sum mod Q.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts out_sum.
REQ-011 The block SHALL have port err_clr, input, 1 bit: synchronous clear of err_range.
REQ-012 The block SHALL have port err_range, output, 1 bit: sticky flag, set when an out-of-range residue was received.

Function
REQ-013 A beat SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1; there is no other means of acceptance.
REQ-014 The FSM SHALL have exactly two states, ACCUM and HOLD.
REQ-015 In ACCUM, in_ready SHALL be 1 and out_valid 0; in HOLD, in_ready SHALL be 0 and out_valid 1.
REQ-016 An accepted value x SHALL be normalised as x' = (x >= Q) ? x - Q : x, giving x' < Q for all 12-bit x.
REQ-017 The accumulator update SHALL be s = acc + x', computed in 13 bits; acc_next = (s >= Q) ? s - Q : s, so acc < Q always.
REQ-018 A beat counter SHALL increment by 1 per accepted beat in ACCUM.
REQ-019 The beat that makes the counter equal FRAME_LEN SHALL move the FSM to HOLD, and out_sum SHALL be loaded with acc_next on that same edge.
REQ-020 out_valid SHALL rise on the cycle after the last beat is accepted (latency 1 cycle).
REQ-021 In HOLD, out_sum SHALL remain stable until the handshake; in_valid and in_data SHALL be ignored.
REQ-022 The edge with out_valid=1 and out_ready=1 SHALL clear acc and the counter to 0 and return the FSM to ACCUM; in_ready SHALL rise on the next cycle, giving exactly one bubble per frame.
REQ-023 out_ready asserted while in ACCUM SHALL have no effect.
REQ-024 With FRAME_LEN=1, every accepted beat SHALL produce a frame whose out_sum = x'.
REQ-025 err_range SHALL set on any accepted beat with in_data >= Q.
REQ-026 err_range SHALL clear on an edge where err_clr=1, except that if err_clr=1 coincides with an out-of-range accepted beat, set wins and err_range stays 1.
REQ-027 An out-of-range beat SHALL still be accumulated using x' and still counted.
REQ-028 out_sum SHALL be driven from a register, never combinationally from in_data.

Reset
REQ-029 While rst_n=0, regardless of clk, the state SHALL be ACCUM and acc, counter, out_sum and err_range SHALL be 0.
REQ-030 While rst_n=0, out_valid SHALL be 0, and in_ready SHALL be 0 while rst_n is low.
REQ-031 in_ready SHALL become 1 on the first clk edge after rst_n deasserts.
REQ-032 Reset asserted mid-frame or in HOLD SHALL discard the partial sum and any pending out_sum without emitting it.

Verification
REQ-033 The bench SHALL cover: FRAME_LEN=4; inputs 1000,1000,1000,1000 back-to-back -> out_valid one cycle after the 4th beat, out_sum=281, err_range=0.
REQ-034 The bench SHALL cover: FRAME_LEN=4; inputs 3718,1,0,0 -> out_sum=0 (exact wrap at Q).
REQ-035 The bench SHALL cover: FRAME_LEN=4; inputs 4000,0,0,0 -> out_sum=281 and err_range=1 from the cycle after beat 1; then err_clr pulse -> err_range=0; err_clr coinciding with in_data=4095 accepted -> err_range stays 1.
REQ-036 The bench SHALL cover: out_ready held 0 for 5 cycles in HOLD with in_valid=1 -> out_sum stable, in_ready=0, no beats counted; after out_ready=1 the next frame of 2,2,2,2 -> out_sum=8.
REQ-037 The bench SHALL cover: rst_n pulsed low after 2 accepted beats of 500 -> no out_valid; the following frame of 1,1,1,1 -> out_sum=4.
REQ-038 The bench SHALL cover: FRAME_LEN=1; inputs 3719 then 5 with out_ready=1 -> out_sum=0 then out_sum=5, with one bubble cycle between beats.
